// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-type and condition-code encodings, NZCV bit positions and the
// condition evaluator used by the EX-stage branch resolver.
package branch_resolve_unit_pkg;

  localparam logic [1:0] BR_NONE   = 2'b00;
  localparam logic [1:0] BR_UNCOND = 2'b01;
  localparam logic [1:0] BR_CBZ    = 2'b10;
  localparam logic [1:0] BR_BCOND  = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  // NV behaves as "always" here, matching the A64 treatment of 4'hF.
  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    logic res;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    res = 1'b1;
    case (cond_e'(cc))
      COND_EQ: res = z;
      COND_NE: res = !z;
      COND_HS: res = c;
      COND_LO: res = !c;
      COND_MI: res = n;
      COND_PL: res = !n;
      COND_VS: res = v;
      COND_VC: res = !v;
      COND_HI: res = c && !z;
      COND_LS: res = !(c && !z);
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = !z && (n == v);
      COND_LE: res = !(!z && (n == v));
      COND_AL: res = 1'b1;
      COND_NV: res = 1'b1;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// Branch history table of 2-bit saturating counters; the read port is
// combinational and sees the pre-update value in a write cycle.
module bht_2bit
  import branch_resolve_unit_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr [2**IDX_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**IDX_W; i++) begin
        ctr[i] <= 2'b01;
      end
    end else if (wr_en) begin
      if (wr_taken && ctr[wr_idx] != 2'b11) begin
        ctr[wr_idx] <= ctr[wr_idx] + 2'b01;
      end else if (!wr_taken && ctr[wr_idx] != 2'b00) begin
        ctr[wr_idx] <= ctr[wr_idx] - 2'b01;
      end
    end
  end

  assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: NZCV flag register with optional forwarding,
// taken/mispredict decision registers and the BHT used for IF prediction.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int BHT_IDX = 4,
  parameter int FWD_EN  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flag_we,
  input  logic [3:0]         flags_in,
  input  logic               br_valid,
  input  logic [1:0]         br_type,
  input  logic [3:0]         br_cond,
  input  logic               br_nz,
  input  logic [DATA_W-1:0]  br_reg,
  input  logic [BHT_IDX-1:0] br_idx,
  input  logic               br_pred,
  input  logic               flush,
  input  logic [BHT_IDX-1:0] lookup_idx,
  output logic               lookup_taken,
  output logic [3:0]         flags_q,
  output logic               take_valid,
  output logic               take_branch,
  output logic               mispredict
);

  logic [3:0] flags_eff;
  logic       resolve;
  logic       taken;

  assign flags_eff = ((FWD_EN != 0) && flag_we) ? flags_in : flags_q;
  assign resolve   = br_valid && (br_type != BR_NONE) && !flush;

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_UNCOND: taken = 1'b1;
      BR_CBZ:    taken = (br_reg == '0) ^ br_nz;
      BR_BCOND:  taken = cond_eval(br_cond, flags_eff);
      default:   taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= 4'b0000;
    end else if (flag_we) begin
      flags_q <= flags_in;
    end
  end

  // Result registers are one-cycle pulses; a non-resolving cycle clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      take_valid  <= 1'b0;
      take_branch <= 1'b0;
      mispredict  <= 1'b0;
    end else begin
      take_valid  <= resolve;
      take_branch <= resolve && taken;
      mispredict  <= resolve && (taken != br_pred);
    end
  end

  bht_2bit #(
    .IDX_W(BHT_IDX)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (lookup_idx),
    .rd_taken (lookup_taken),
    .wr_en    (resolve),
    .wr_idx   (br_idx),
    .wr_taken (taken)
  );

endmodule
